// File: rtl/cluster_merge_sorter.sv
// Pipelined Batcher odd-even merge of two pre-sorted cluster halves into the MXOUT lowest-address valid clusters.
// Define INPUT_LATCH_EN to register the inputs ahead of the first compare stage (adds one cycle of latency).
module cluster_merge_sorter #(
  parameter int MXHALF    = 8,
  parameter int MXOUT     = 8,
  parameter int MXADRBITS = 11,
  parameter int MXCNTBITS = 3,
  parameter int MXOVFBITS = 16
) (
  input  logic                          clock4x,
  input  logic                          reset_n,
  input  logic [2*MXHALF*MXADRBITS-1:0] adr_in,
  input  logic [2*MXHALF*MXCNTBITS-1:0] cnt_in,
  input  logic [2*MXHALF-1:0]           vpf_in,
  input  logic                          valid_in,
  output logic [MXOUT*MXADRBITS-1:0]    adr_out,
  output logic [MXOUT*MXCNTBITS-1:0]    cnt_out,
  output logic [MXOUT-1:0]              vpf_out,
  output logic                          valid_out,
  output logic                          overflow,
  output logic [MXOVFBITS-1:0]          overflow_cnt
);
  localparam int N2   = 2 * MXHALF;
  localparam int NSTG = $clog2(N2);
`ifdef INPUT_LATCH_EN
  localparam int LAT  = NSTG + 1;
`else
  localparam int LAT  = NSTG;
`endif

  // Compare partner of a position in a stage of the odd-even merge, -1 when it passes through.
  function automatic int partner(input int s, input int pos);
    int k;
    k = MXHALF >> s;
    if (s == 0) return (pos < MXHALF) ? pos + MXHALF : pos - MXHALF;
    if (((pos / k) % 2) == 1 && (pos + k) < N2) return pos + k;
    if (pos >= 2 * k && ((pos / k) % 2) == 0) return pos - k;
    return -1;
  endfunction

  function automatic logic [MXADRBITS:0] sort_key(input logic v, input logic [MXADRBITS-1:0] a);
    return {~v, a};
  endfunction

  function automatic logic [MXOVFBITS-1:0] sat_inc(input logic [MXOVFBITS-1:0] v);
    return (v == '1) ? v : v + MXOVFBITS'(1);
  endfunction

  logic [MXADRBITS-1:0] w_src_adr [N2];
  logic [MXCNTBITS-1:0] w_src_cnt [N2];
  logic                 w_src_vpf [N2];

  logic [MXADRBITS-1:0] w_in_adr  [NSTG][N2];
  logic [MXCNTBITS-1:0] w_in_cnt  [NSTG][N2];
  logic                 w_in_vpf  [NSTG][N2];
  logic [MXADRBITS-1:0] w_nxt_adr [NSTG][N2];
  logic [MXCNTBITS-1:0] w_nxt_cnt [NSTG][N2];
  logic                 w_nxt_vpf [NSTG][N2];
  logic [MXADRBITS-1:0] r_stg_adr [NSTG][N2];
  logic [MXCNTBITS-1:0] r_stg_cnt [NSTG][N2];
  logic                 r_stg_vpf [NSTG][N2];

  logic [LAT-1:0]       r_vld;
  logic [LAT-1:0]       r_ovf;
  logic [MXOVFBITS-1:0] r_ovf_cnt;
  logic                 w_ovf_in;

  assign w_ovf_in = $countones(vpf_in) > MXOUT;

`ifdef INPUT_LATCH_EN
  // Input register: invalid slots are parked at the all-ones key so they never disturb the merge.
  logic [MXADRBITS-1:0] r_lat_adr [N2];
  logic [MXCNTBITS-1:0] r_lat_cnt [N2];
  logic                 r_lat_vpf [N2];

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < N2; p++) begin
        r_lat_adr[p] <= '1;
        r_lat_cnt[p] <= '0;
        r_lat_vpf[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < N2; p++) begin
        r_lat_vpf[p] <= vpf_in[p];
        r_lat_adr[p] <= vpf_in[p] ? adr_in[p*MXADRBITS +: MXADRBITS] : '1;
        r_lat_cnt[p] <= vpf_in[p] ? cnt_in[p*MXCNTBITS +: MXCNTBITS] : '0;
      end
    end
  end

  assign w_src_adr = r_lat_adr;
  assign w_src_cnt = r_lat_cnt;
  assign w_src_vpf = r_lat_vpf;
`else
  for (genvar p = 0; p < N2; p++) begin : g_src
    assign w_src_adr[p] = adr_in[p*MXADRBITS +: MXADRBITS];
    assign w_src_cnt[p] = cnt_in[p*MXCNTBITS +: MXCNTBITS];
    assign w_src_vpf[p] = vpf_in[p];
  end
`endif

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    for (genvar p = 0; p < N2; p++) begin : g_pos
      localparam int PT = partner(s, p);
      localparam int PS = (PT < 0) ? p : PT;
      localparam int LO = (PS < p) ? PS : p;
      localparam int HI = (PS < p) ? p : PS;
      logic w_swap;

      if (s == 0) begin : g_first
        assign w_in_adr[s][p] = w_src_adr[p];
        assign w_in_cnt[s][p] = w_src_cnt[p];
        assign w_in_vpf[s][p] = w_src_vpf[p];
      end else begin : g_next
        assign w_in_adr[s][p] = r_stg_adr[s-1][p];
        assign w_in_cnt[s][p] = r_stg_cnt[s-1][p];
        assign w_in_vpf[s][p] = r_stg_vpf[s-1][p];
      end

      // Strict greater-than keeps equal keys in place, so the lower slot stays ahead.
      assign w_swap = sort_key(w_in_vpf[s][LO], w_in_adr[s][LO]) >
                      sort_key(w_in_vpf[s][HI], w_in_adr[s][HI]);
      assign w_nxt_adr[s][p] = w_swap ? w_in_adr[s][PS] : w_in_adr[s][p];
      assign w_nxt_cnt[s][p] = w_swap ? w_in_cnt[s][PS] : w_in_cnt[s][p];
      assign w_nxt_vpf[s][p] = w_swap ? w_in_vpf[s][PS] : w_in_vpf[s][p];
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSTG; s++) begin
        for (int p = 0; p < N2; p++) begin
          r_stg_adr[s][p] <= '1;
          r_stg_cnt[s][p] <= '0;
          r_stg_vpf[s][p] <= 1'b0;
        end
      end
      r_vld     <= '0;
      r_ovf     <= '0;
      r_ovf_cnt <= '0;
    end else begin
      r_stg_adr <= w_nxt_adr;
      r_stg_cnt <= w_nxt_cnt;
      r_stg_vpf <= w_nxt_vpf;
      r_vld     <= {r_vld[LAT-2:0], valid_in};
      r_ovf     <= {r_ovf[LAT-2:0], w_ovf_in};
      // Count as the frame enters the output register so the count already includes it.
      if (r_vld[LAT-2] && r_ovf[LAT-2]) r_ovf_cnt <= sat_inc(r_ovf_cnt);
    end
  end

  for (genvar o = 0; o < MXOUT; o++) begin : g_out
    assign vpf_out[o] = r_stg_vpf[NSTG-1][o];
    assign adr_out[o*MXADRBITS +: MXADRBITS] = r_stg_vpf[NSTG-1][o] ? r_stg_adr[NSTG-1][o] : '1;
    assign cnt_out[o*MXCNTBITS +: MXCNTBITS] = r_stg_vpf[NSTG-1][o] ? r_stg_cnt[NSTG-1][o] : '0;
  end

  assign valid_out    = r_vld[LAT-1];
  assign overflow     = r_vld[LAT-1] & r_ovf[LAT-1];
  assign overflow_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_cluster_merge_sorter.sv
// Scoreboard bench for cluster_merge_sorter: a driver queues reference results, a monitor checks each output frame.
module tb_cluster_merge_sorter;
  localparam int MXHALF = 8;
  localparam int MXOUT  = 8;
  localparam int A      = 11;
  localparam int C      = 3;
  localparam int OVB    = 4;
  localparam int N2     = 2 * MXHALF;
  localparam int OVMAX  = (1 << OVB) - 1;
  localparam int TCK    = 10;
`ifdef INPUT_LATCH_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic                   clock4x = 1'b0;
  logic                   reset_n;
  logic [N2*A-1:0]        adr_in;
  logic [N2*C-1:0]        cnt_in;
  logic [N2-1:0]          vpf_in;
  logic                   valid_in;
  logic [MXOUT*A-1:0]     adr_out;
  logic [MXOUT*C-1:0]     cnt_out;
  logic [MXOUT-1:0]       vpf_out;
  logic                   valid_out;
  logic                   overflow;
  logic [OVB-1:0]         overflow_cnt;

  cluster_merge_sorter #(
    .MXHALF(MXHALF), .MXOUT(MXOUT), .MXADRBITS(A), .MXCNTBITS(C), .MXOVFBITS(OVB)
  ) dut (
    .clock4x(clock4x), .reset_n(reset_n), .adr_in(adr_in), .cnt_in(cnt_in),
    .vpf_in(vpf_in), .valid_in(valid_in), .adr_out(adr_out), .cnt_out(cnt_out),
    .vpf_out(vpf_out), .valid_out(valid_out), .overflow(overflow), .overflow_cnt(overflow_cnt)
  );

  always #5 clock4x = ~clock4x;

  typedef struct {
    logic [MXOUT*A-1:0] adr;
    logic [MXOUT*C-1:0] cnt;
    logic [MXOUT-1:0]   vpf;
    logic               ovf;
    longint             t;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           model_ovf = 0;
  logic [A-1:0] fa [N2];
  logic [C-1:0] fc [N2];
  logic         fv [N2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: gather valid clusters, order by address (earlier slot first on ties), keep the lowest MXOUT.
  function automatic exp_t model(input longint t_due);
    exp_t e;
    int   order[$];
    int   j;
    for (int i = 0; i < N2; i++) begin
      if (fv[i]) begin
        j = 0;
        while (j < order.size() && fa[order[j]] <= fa[i]) j++;
        order.insert(j, i);
      end
    end
    e.adr = '1;
    e.cnt = '0;
    e.vpf = '0;
    for (int o = 0; o < MXOUT; o++) begin
      if (o < order.size()) begin
        e.adr[o*A +: A] = fa[order[o]];
        e.cnt[o*C +: C] = fc[order[o]];
        e.vpf[o]        = 1'b1;
      end
    end
    e.ovf = order.size() > MXOUT;
    e.t   = t_due;
    return e;
  endfunction

  task automatic put_ports(input bit v);
    for (int i = 0; i < N2; i++) begin
      adr_in[i*A +: A] = fa[i];
      cnt_in[i*C +: C] = fc[i];
      vpf_in[i]        = fv[i];
    end
    valid_in = v;
  endtask

  // Each half: an ascending prefix of valid clusters (lower even, upper odd addresses), random junk after.
  task automatic rand_frame(input bit full);
    int n;
    int base;
    for (int h = 0; h < 2; h++) begin
      n    = full ? MXHALF : $urandom_range(0, MXHALF);
      base = $urandom_range(0, 100) * 2 + h;
      for (int i = 0; i < MXHALF; i++) begin
        fc[h*MXHALF+i] = C'($urandom);
        if (i < n) begin
          fv[h*MXHALF+i] = 1'b1;
          fa[h*MXHALF+i] = A'(base);
          base += 2 * $urandom_range(1, 100);
        end else begin
          fv[h*MXHALF+i] = 1'b0;
          fa[h*MXHALF+i] = A'($urandom);
        end
      end
    end
  endtask

  task automatic issue(input bit v);
    @(negedge clock4x);
    put_ports(v);
    if (v) sb.push_back(model(longint'($time) + LAT * TCK));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rand_frame(1'b0);
      issue(1'b0);
    end
  endtask

  task automatic check_cleared(input string tag);
    logic [MXOUT*A-1:0] ones;
    ones = '1;
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_vpf_out"}, vpf_out, 0);
    chk({tag, "_adr_out"}, adr_out, ones);
    chk({tag, "_cnt_out"}, cnt_out, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_overflow_cnt"}, overflow_cnt, 0);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N2; i++) begin
      fv[i] = 1'b0;
      fa[i] = A'($urandom);
      fc[i] = C'($urandom);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock4x);
      if (reset_n === 1'b1) begin
        if (valid_out) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=valid_out=1 required=no frame pending at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk("latency_time", 128'($time), 128'(e.t));
            chk("adr_out", adr_out, e.adr);
            chk("cnt_out", cnt_out, e.cnt);
            chk("vpf_out", vpf_out, e.vpf);
            chk("overflow", overflow, e.ovf);
            if (e.ovf && model_ovf < OVMAX) model_ovf++;
            chk("overflow_cnt", overflow_cnt, model_ovf);
          end
        end else begin
          chk("overflow_idle", overflow, 0);
        end
      end
    end
  end

  initial begin : driver
    int la[MXHALF] = '{3, 10, 20, 30, 40, 50, 60, 70};
    int ua[MXHALF] = '{1, 5, 12, 25, 35, 45, 55, 65};
    reset_n = 1'b0;
    clear_frame();
    put_ports(1'b0);

    // Reset held with live traffic on the inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clock4x);
      rand_frame(1'b0);
      put_ports(1'b1);
      #1 check_cleared("reset_hold");
    end
    @(negedge clock4x);
    valid_in = 1'b0;
    reset_n  = 1'b1;

    // Full merge of two dense halves
    for (int i = 0; i < MXHALF; i++) begin
      fa[i] = A'(la[i]);          fv[i] = 1'b1;          fc[i] = C'($urandom);
      fa[MXHALF+i] = A'(ua[i]);   fv[MXHALF+i] = 1'b1;   fc[MXHALF+i] = C'($urandom);
    end
    issue(1'b1);

    // Sparse: valid all-ones address in the lower half, one low address in the upper half
    clear_frame();
    fv[2] = 1'b1;       fa[2] = 11'h7FF;       fc[2] = 3'd5;
    fv[MXHALF] = 1'b1;  fa[MXHALF] = 11'h004;  fc[MXHALF] = 3'd2;
    issue(1'b1);

    // Tie between the heads of both halves
    clear_frame();
    fv[0] = 1'b1;       fa[0] = 11'h050;       fc[0] = 3'd1;
    fv[MXHALF] = 1'b1;  fa[MXHALF] = 11'h050;  fc[MXHALF] = 3'd6;
    issue(1'b1);

    // Back-to-back stream
    for (int i = 0; i < 20; i++) begin
      rand_frame(1'b0);
      issue(1'b1);
    end
    idle(LAT + 2);

    // Random traffic with gaps
    for (int i = 0; i < 40; i++) begin
      rand_frame($urandom_range(0, 3) == 0);
      issue($urandom_range(0, 3) != 0);
    end
    idle(LAT + 2);

    // Reset while frames are in flight and one is on the output
    for (int i = 0; i < LAT + 2; i++) begin
      rand_frame(1'b1);
      issue(1'b1);
    end
    @(negedge clock4x);
    valid_in = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_cleared("async_reset");
    sb.delete();
    model_ovf = 0;
    repeat (2) @(negedge clock4x);
    reset_n = 1'b1;
    idle(LAT + 3);

    // Counter saturation
    for (int i = 0; i < 17; i++) begin
      rand_frame(1'b1);
      issue(1'b1);
    end
    idle(LAT + 2);
    chk("overflow_cnt_saturated", overflow_cnt, OVMAX);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
